io_port_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU's I/O bus; it answers the IOR/IOW accesses that the control unit issues.
- The control unit signals an access with iom=1. wen=1 marks a read and wen=0 marks a write (active-low write).
- Buffers outgoing words in a TX FIFO and incoming words in an RX FIFO.
- Exchanges data with the external world over valid/ready streams, with an optional internal loopback.

---
 rtl/io_port_responder.sv | 189 ++++++++++++++++++
 tb/tb_io_port_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped I/O responder for the CPU I/O bus.
// Registers: DATA (0), STATUS (1), CTRL (2), reserved (3).
// CPU writes to DATA go into a TX FIFO that drains to a valid/ready stream.
// Words arriving on the RX stream go into an RX FIFO that CPU DATA reads drain.
// CTRL.loopback routes TX head words straight into the RX FIFO.
module io_port_responder #(
   parameter int DEPTH = 4,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          iom_in,
   input  logic          wen_in,
   input  logic [15:0]   addr_in,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   output logic          tx_valid_out,
   output logic [DW-1:0] tx_data_out,
   input  logic          tx_ready_in,
   input  logic          rx_valid_in,
   input  logic [DW-1:0] rx_data_in,
   output logic          rx_ready_out
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_FULL = 4'(DEPTH);

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_CTRL   = 2'd2;

   // FIFO storage (data only, never reset: pointers/counts define validity)
   logic [DW-1:0] tx_mem_q [DEPTH];
   logic [DW-1:0] rx_mem_q [DEPTH];

   // FIFO pointers and occupancy counts
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [3:0]    tx_cnt_q, tx_cnt_d;
   logic [3:0]    rx_cnt_q, rx_cnt_d;

   // Control register and sticky error flags
   logic [2:0]    ctrl_q, ctrl_d;
   logic          tx_ovf_q, tx_ovf_d;
   logic          rx_udf_q, rx_udf_d;

   // Decoded access and FIFO event strobes
   logic          rd_cyc, wr_cyc;
   logic [1:0]    reg_sel;
   logic          tx_en, rx_en, loopback;
   logic          tx_empty, tx_full, rx_empty, rx_full;
   logic          lb_move;
   logic          tx_push, tx_pop;
   logic          rx_push, rx_pop;
   logic [DW-1:0] rx_wdata;
   logic [DW-1:0] tx_head, rx_head;
   logic [15:0]   status_word;
   logic          flag_clr;

   // Upper address bits are not decoded
   logic          unused_addr;
   assign unused_addr = ^addr_in[15:2];

   // Bus decode, FIFO flags and per-cycle push/pop strobes from registered state
   always_comb begin
      rd_cyc   = rst_n & iom_in & wen_in;
      wr_cyc   = rst_n & iom_in & ~wen_in;
      reg_sel  = addr_in[1:0];

      tx_en    = ctrl_q[0];
      rx_en    = ctrl_q[1];
      loopback = ctrl_q[2];

      tx_empty = (tx_cnt_q == 4'd0);
      tx_full  = (tx_cnt_q == CNT_FULL);
      rx_empty = (rx_cnt_q == 4'd0);
      rx_full  = (rx_cnt_q == CNT_FULL);

      tx_head  = tx_mem_q[tx_rp_q];
      rx_head  = rx_mem_q[rx_rp_q];

      // Loopback ignores tx_en/rx_en and takes priority over both streams
      lb_move      = loopback & ~tx_empty & ~rx_full;
      tx_valid_out = ~loopback & tx_en & ~tx_empty;
      rx_ready_out = ~loopback & rx_en & ~rx_full;
      tx_data_out  = tx_valid_out ? tx_head : '0;

      // Full/empty decisions use pre-edge state, so a full TX drops the word
      // even when the stream drains an entry in the same cycle
      tx_push  = wr_cyc & (reg_sel == A_DATA) & ~tx_full;
      tx_pop   = (tx_valid_out & tx_ready_in) | lb_move;
      rx_pop   = rd_cyc & (reg_sel == A_DATA) & ~rx_empty;
      rx_push  = (rx_valid_in & rx_ready_out) | lb_move;
      rx_wdata = lb_move ? tx_head : rx_data_in;

      flag_clr = wr_cyc & (reg_sel == A_STATUS) & data_in[0];
   end

   // STATUS word assembly
   always_comb begin
      status_word        = '0;
      status_word[0]     = rx_empty;
      status_word[1]     = rx_full;
      status_word[2]     = tx_empty;
      status_word[3]     = tx_full;
      status_word[4]     = tx_ovf_q;
      status_word[5]     = rx_udf_q;
      status_word[11:8]  = rx_cnt_q;
      status_word[15:12] = tx_cnt_q;
   end

   // Combinational read data; zero whenever the cycle is not a read
   always_comb begin
      data_out = '0;
      if (rd_cyc) begin
         case (reg_sel)
            A_DATA:   data_out = rx_empty ? '0 : rx_head;
            A_STATUS: data_out = status_word;
            A_CTRL:   data_out = {{(DW-3){1'b0}}, ctrl_q};
            default:  data_out = '0;
         endcase
      end
   end

   // Next-state for pointers, counts, control register and sticky flags
   always_comb begin
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      ctrl_d   = ctrl_q;
      tx_ovf_d = tx_ovf_q;
      rx_udf_d = rx_udf_q;

      if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
      if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);

      // Simultaneous push and pop leave the count unchanged
      tx_cnt_d = tx_cnt_q + 4'(tx_push) - 4'(tx_pop);
      rx_cnt_d = rx_cnt_q + 4'(rx_push) - 4'(rx_pop);

      if (wr_cyc && reg_sel == A_DATA && tx_full)  tx_ovf_d = 1'b1;
      if (rd_cyc && reg_sel == A_DATA && rx_empty) rx_udf_d = 1'b1;
      if (flag_clr) begin
         tx_ovf_d = 1'b0;
         rx_udf_d = 1'b0;
      end

      if (wr_cyc && reg_sel == A_CTRL) ctrl_d = data_in[2:0];
   end

   // Control state register; reset empties both FIFOs and clears CTRL/flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         ctrl_q   <= '0;
         tx_ovf_q <= 1'b0;
         rx_udf_q <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         ctrl_q   <= ctrl_d;
         tx_ovf_q <= tx_ovf_d;
         rx_udf_q <= rx_udf_d;
      end
   end

   // TX FIFO storage write
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= data_in;
   end

   // RX FIFO storage write (external stream or loopback)
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_wdata;
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Testbench for io_port_responder: queue-based reference model with a
// per-cycle scoreboard checked by an independent monitor.
module tb_io_port_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iom_in = 1'b0;
   logic        wen_in = 1'b0;
   logic [15:0] addr_in = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        tx_valid_out;
   logic [15:0] tx_data_out;
   logic        tx_ready_in = 1'b0;
   logic        rx_valid_in = 1'b0;
   logic [15:0] rx_data_in = '0;
   logic        rx_ready_out;

   io_port_responder #(.DEPTH(DEPTH), .DW(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .iom_in      (iom_in),
      .wen_in      (wen_in),
      .addr_in     (addr_in),
      .data_in     (data_in),
      .data_out    (data_out),
      .tx_valid_out(tx_valid_out),
      .tx_data_out (tx_data_out),
      .tx_ready_in (tx_ready_in),
      .rx_valid_in (rx_valid_in),
      .rx_data_in  (rx_data_in),
      .rx_ready_out(rx_ready_out)
   );

   always #5 clk = ~clk;

   // Expected DUT outputs for one clock cycle
   typedef struct {
      logic [15:0] dout;
      logic        txv;
      logic [15:0] txd;
      logic        rxr;
      logic        kv;
      logic [15:0] k;
   } rec_t;

   rec_t sb[$];

   // Reference model state
   logic [15:0] txq[$];
   logic [15:0] rxq[$];
   logic [2:0]  m_ctrl;
   logic        m_ovf, m_udf;

   int  checks = 0;
   int  failures = 0;
   bit  done = 0;

   function automatic logic [15:0] m_status();
      logic [15:0] s;
      s = '0;
      s[0]     = (rxq.size() == 0);
      s[1]     = (rxq.size() == DEPTH);
      s[2]     = (txq.size() == 0);
      s[3]     = (txq.size() == DEPTH);
      s[4]     = m_ovf;
      s[5]     = m_udf;
      s[11:8]  = 4'(rxq.size());
      s[15:12] = 4'(txq.size());
      return s;
   endfunction

   task automatic model_clear();
      txq.delete();
      rxq.delete();
      m_ctrl = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // One bus cycle: drive inputs, queue the expected outputs, advance the model
   task automatic cyc(input logic iom, input logic wen, input logic [15:0] a,
                      input logic [15:0] d, input logic txr, input logic rxv,
                      input logic [15:0] rxd, input logic kv, input logic [15:0] k);
      rec_t r;
      logic rd, wr, lbmv, txfull, rxempty;
      logic [15:0] w;
      @(posedge clk);
      #1;
      rst_n = 1'b1; iom_in = iom; wen_in = wen; addr_in = a; data_in = d;
      tx_ready_in = txr; rx_valid_in = rxv; rx_data_in = rxd;

      rd = iom & wen;
      wr = iom & ~wen;
      r.txv = !m_ctrl[2] && m_ctrl[0] && txq.size() != 0;
      r.txd = r.txv ? txq[0] : 16'h0;
      r.rxr = !m_ctrl[2] && m_ctrl[1] && rxq.size() < DEPTH;
      r.dout = 16'h0;
      if (rd) begin
         case (a[1:0])
            2'd0: r.dout = (rxq.size() != 0) ? rxq[0] : 16'h0;
            2'd1: r.dout = m_status();
            2'd2: r.dout = {13'h0, m_ctrl};
            default: r.dout = 16'h0;
         endcase
      end
      r.kv = kv;
      r.k  = k;
      sb.push_back(r);

      txfull  = (txq.size() == DEPTH);
      rxempty = (rxq.size() == 0);
      lbmv    = m_ctrl[2] && txq.size() != 0 && rxq.size() < DEPTH;
      w = 16'h0;
      if (lbmv) w = txq.pop_front();
      else if (r.txv && txr) void'(txq.pop_front());
      if (wr && a[1:0] == 2'd0) begin
         if (txfull) m_ovf = 1'b1;
         else txq.push_back(d);
      end
      if (rd && a[1:0] == 2'd0) begin
         if (rxempty) m_udf = 1'b1;
         else void'(rxq.pop_front());
      end
      if (rxv && r.rxr) rxq.push_back(rxd);
      if (lbmv) rxq.push_back(w);
      if (wr && a[1:0] == 2'd1 && d[0]) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (wr && a[1:0] == 2'd2) m_ctrl = d[2:0];
   endtask

   // One cycle held in reset, asserted asynchronously mid-cycle
   task automatic rst_cyc();
      rec_t r;
      @(posedge clk);
      #1;
      rst_n = 1'b0; iom_in = 1'b0; wen_in = 1'b0; addr_in = '0; data_in = '0;
      tx_ready_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = '0;
      model_clear();
      r.dout = 16'h0; r.txv = 1'b0; r.txd = 16'h0; r.rxr = 1'b0;
      r.kv = 1'b0; r.k = 16'h0;
      sb.push_back(r);
   endtask

   task automatic wreg(input logic [15:0] a, input logic [15:0] d, input logic txr);
      cyc(1'b1, 1'b0, a, d, txr, 1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic rreg(input logic [15:0] a, input logic [15:0] k, input logic txr);
      cyc(1'b1, 1'b1, a, 16'h0, txr, 1'b0, 16'h0, 1'b1, k);
   endtask

   task automatic idle(input logic txr);
      cyc(1'b0, 1'b0, 16'h0, 16'h0, txr, 1'b0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs mid-cycle against the queued expectations
   initial begin : monitor
      rec_t r;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            r = sb.pop_front();
            check("data_out", data_out, r.dout);
            check("tx_valid_out", {15'h0, tx_valid_out}, {15'h0, r.txv});
            check("tx_data_out", tx_data_out, r.txd);
            check("rx_ready_out", {15'h0, rx_ready_out}, {15'h0, r.rxr});
            if (r.kv) check("directed_read", data_out, r.k);
         end else if (done) begin
            break;
         end
      end
      check("scoreboard_drained", 16'(sb.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int ptx, prx;
      logic [15:0] a, d;
      model_clear();
      repeat (3) rst_cyc();

      // Reset state
      rreg(16'h1, 16'h0005, 1'b0);
      rreg(16'h2, 16'h0000, 1'b0);

      // TX stream with back-pressure, then drain
      wreg(16'h2, 16'h0003, 1'b0);
      wreg(16'h0, 16'hA5A5, 1'b0);
      wreg(16'h0, 16'h1234, 1'b0);
      idle(1'b0);
      idle(1'b0);
      rreg(16'h1, 16'h2001, 1'b0);
      idle(1'b1);
      idle(1'b1);
      rreg(16'h1, 16'h0005, 1'b0);

      // TX overflow and flag clear
      for (int i = 0; i < 5; i++) wreg(16'h0, 16'(16'h0100 + i), 1'b0);
      rreg(16'h1, 16'h4019, 1'b0);
      wreg(16'h1, 16'h0001, 1'b0);
      rreg(16'h1, 16'h4009, 1'b0);
      repeat (4) idle(1'b1);
      rreg(16'h1, 16'h0005, 1'b0);

      // RX fill, drain and underflow
      wreg(16'h2, 16'h0002, 1'b0);
      for (int i = 1; i <= 4; i++)
         cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'(i), 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0099, 1'b0, 16'h0);
      for (int i = 1; i <= 4; i++) rreg(16'h0, 16'(i), 1'b0);
      rreg(16'h0, 16'h0000, 1'b0);
      rreg(16'h1, 16'h0025, 1'b0);
      wreg(16'h1, 16'h0001, 1'b0);

      // Loopback
      wreg(16'h2, 16'h0004, 1'b0);
      wreg(16'h0, 16'h00FF, 1'b1);
      wreg(16'h0, 16'h0F0F, 1'b1);
      idle(1'b1);
      idle(1'b1);
      rreg(16'h0, 16'h00FF, 1'b0);
      rreg(16'h0, 16'h0F0F, 1'b0);

      // Reset with both FIFOs holding three entries
      wreg(16'h2, 16'h0003, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 16'h0, 16'(16'h0100 + i), 1'b0, 1'b1, 16'(16'h0200 + i), 1'b0, 16'h0);
      rreg(16'h1, 16'h3300, 1'b0);
      rst_cyc();
      rst_cyc();
      idle(1'b0);
      rreg(16'h2, 16'h0000, 1'b0);
      rreg(16'h1, 16'h0005, 1'b0);

      // Randomized traffic with phase-varying stream pressure
      ptx = 50; prx = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 200 == 0) begin
            ptx = $urandom_range(0, 2) * 45;
            prx = $urandom_range(0, 2) * 45;
         end
         if ($urandom_range(0, 799) == 0) begin
            rst_cyc();
         end else begin
            a = 16'($urandom);
            d = 16'($urandom);
            if (a[1:0] == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'd0;
            cyc(1'($urandom_range(0, 9) < 6), 1'($urandom), a, d,
                1'($urandom_range(0, 99) < ptx), 1'($urandom_range(0, 99) < prx),
                16'($urandom), 1'b0, 16'h0);
         end
      end
      idle(1'b0);
      @(posedge clk);
      done = 1;
   end

endmodule
